operand_fetch: RTL
==================

# operand_fetch

Operand-fetch stage directly upstream of the ALU. It holds the 32 x 64-bit integer register file, reads two source registers for each accepted instruction, and registers the operands together with the 4-bit ALU operation into a one-deep output stage. That output stage drives the ALU's `ALUOp`, `Read_data_1` and `Read_data_2` inputs under a valid/ready handshake. The write-back port writes the register file. Write-back results are bypassed into both the fetch path and the stalled output stage, so the ALU never consumes a stale operand.

## Interface
- `XLEN`, 64, data width of registers and operands
- `NREG`, 32, number of architectural registers; index width is log2(NREG) = 5

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high
- `in_valid`  in  1  decode presents an instruction
- `in_ready`  out  1  stage can accept this cycle
- `Read_register_1`  in  5  rs1 index
- `Read_register_2`  in  5  rs2 index
- `ALUOp_in`  in  4  operation code passed through to the ALU
- `RegWrite`  in  1  write-back enable
- `Write_register`  in  5  rd index
- `Write_data`  in  XLEN  write-back value
- `out_valid`  out  1  operands valid toward the ALU
- `out_ready`  in  1  ALU/EX side consumes this cycle
- `ALUOp`  out  4  registered operation code
- `Read_data_1`  out  XLEN  registered rs1 operand
- `Read_data_2`  out  XLEN  registered rs2 operand

## Operation
- Register file: NREG x XLEN.
  - x0 always reads 0.
  - Writes with `Write_register`=0 are ignored.
  - All entries are cleared by reset.
- Write: when `RegWrite`=1 and `Write_register`≠0, `Write_data` is stored at the clock edge.
- Read with bypass: each source value is `Write_data` if `RegWrite`=1 and `Write_register`≠0 and `Write_register` equals the source index. Otherwise it is the array contents, or 0 for index 0.
- Handshake:
  - `in_ready` = !`out_valid` || `out_ready` (combinational).
  - Accept = `in_valid` && `in_ready`.
  - Drain = `out_valid` && `out_ready`.
- On accept, the output stage captures:
  - `ALUOp_in`;
  - both bypassed source values;
  - both source indices, held internally for refresh.
  - `out_valid` is set to 1.
- On drain without accept, `out_valid` is cleared. The data outputs keep their last values.
- Hold (`out_valid`=1, `out_ready`=0): `ALUOp` and the indices stay stable. If a write hits a held nonzero index, the corresponding held operand is replaced with `Write_data` at that edge (operand refresh). Both operands refresh if both indices match.
- Drain and accept in the same cycle: new data is captured and `out_valid` stays 1.
- `out_ready` asserted while `out_valid`=0 has no effect.
- State machine, two states:
  - EMPTY (`out_valid`=0): accept → FULL.
  - FULL: drain without accept → EMPTY; drain+accept → FULL with new data; hold → FULL with refresh.

## Timing
- Latency: accepted at edge N → `out_valid`, `ALUOp` and operands visible after edge N, in cycle N+1.
- Throughput: one instruction per cycle while `out_ready`=1.
- Write at edge N is readable through the array from cycle N+1, and through the bypass in cycle N itself.
- Reset (synchronous, dominant over every other event, including an in-flight write or accept), after the edge:
  - `out_valid`=0, `ALUOp`=0, `Read_data_1`=`Read_data_2`=0;
  - all registers 0;
  - `in_ready`=1 in the following cycle.
- Reset mid-hold discards the held instruction.
- `in_ready` depends combinationally on `out_ready`. There is no combinational path from `in_valid` to `out_valid`.

## Test plan
- Reset then idle:
  - all outputs 0 and `in_ready`=1;
  - an accept reading x5, x6 with `ALUOp_in`=4'b0010 gives `Read_data_1`=`Read_data_2`=0, `ALUOp`=4'b0010 next cycle.
- Write x5=64'h1234, then the next cycle accept rs1=x5, rs2=x0 → `Read_data_1`=64'h1234, `Read_data_2`=0.
- Same-cycle bypass: write x7=64'hDEAD_BEEF while accepting rs1=rs2=x7 → both operands 64'hDEAD_BEEF next cycle. A write to x0=64'hFF while reading x0 → operand 0.
- Backpressure with refresh:
  - accept rs1=x3 (value 1), hold `out_ready`=0 for 3 cycles;
  - in cycle 2 write x3=64'h99 → `Read_data_1` becomes 64'h99, `ALUOp` unchanged, `in_ready`=0 throughout;
  - raise `out_ready` → drains.
- Streaming: `in_valid`=`out_ready`=1 for 4 instructions with `ALUOp_in` 0000, 0001, 0010, 0110 → `out_valid` stays 1 and the ALU sees the ops in order, one per cycle.
- Reset while FULL and writing x9 → `out_valid`=0 after the edge; a later read of x9 returns 0.

Source files
------------

// File: rtl/operand_fetch.sv
// Operand-fetch stage: 32x64 register file with write-back bypass, feeding a
// one-deep valid/ready output register toward the ALU with held-operand refresh.

module of_src_port #(
   parameter int XLEN = 64,
   parameter int IDXW = 5
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            hold,
   input  logic [IDXW-1:0] src_idx,
   input  logic [XLEN-1:0] rf_rdata,
   input  logic            wb_en,
   input  logic [IDXW-1:0] wb_idx,
   input  logic [XLEN-1:0] wb_data,
   output logic [XLEN-1:0] operand
);
   logic [IDXW-1:0] idx_q;
   logic [XLEN-1:0] fetch_val;

   // wb_en already excludes x0, so a bypass hit can never produce a nonzero x0
   always_comb begin
      fetch_val = rf_rdata;
      if (wb_en && (wb_idx == src_idx))
         fetch_val = wb_data;
      else if (src_idx == '0)
         fetch_val = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         operand <= '0;
         idx_q   <= '0;
      end else if (load) begin
         operand <= fetch_val;
         idx_q   <= src_idx;
      end else if (hold && wb_en && (wb_idx == idx_q)) begin
         operand <= wb_data;
      end
   end
endmodule

module operand_fetch #(
   parameter int XLEN = 64,
   parameter int NREG = 32
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [$clog2(NREG)-1:0] Read_register_1,
   input  logic [$clog2(NREG)-1:0] Read_register_2,
   input  logic [3:0]              ALUOp_in,
   input  logic                    RegWrite,
   input  logic [$clog2(NREG)-1:0] Write_register,
   input  logic [XLEN-1:0]         Write_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [3:0]              ALUOp,
   output logic [XLEN-1:0]         Read_data_1,
   output logic [XLEN-1:0]         Read_data_2
);
   localparam int IDXW   = $clog2(NREG);
   localparam int NPORTS = 2;

   typedef enum logic {EMPTY, FULL} state_t;

   state_t state_q, state_d;
   logic [XLEN-1:0] rf [NREG];
   logic wb_en, accept, drain, hold;
   logic [NPORTS-1:0][IDXW-1:0] src_idx;
   logic [NPORTS-1:0][XLEN-1:0] operand;

   assign wb_en     = RegWrite && (Write_register != '0);
   assign out_valid = (state_q == FULL);
   assign in_ready  = !out_valid || out_ready;
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid && out_ready;
   assign hold      = out_valid && !out_ready;
   assign src_idx   = {Read_register_2, Read_register_1};

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else if (wb_en) begin
         rf[Write_register] <= Write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) state_q <= EMPTY;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY: if (accept) state_d = FULL;
         FULL:  if (drain && !accept) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset)       ALUOp <= '0;
      else if (accept) ALUOp <= ALUOp_in;
   end

   for (genvar p = 0; p < NPORTS; p++) begin : g_src
      of_src_port #(.XLEN(XLEN), .IDXW(IDXW)) u_port (
         .clk      (clk),
         .reset    (reset),
         .load     (accept),
         .hold     (hold),
         .src_idx  (src_idx[p]),
         .rf_rdata (rf[src_idx[p]]),
         .wb_en    (wb_en),
         .wb_idx   (Write_register),
         .wb_data  (Write_data),
         .operand  (operand[p])
      );
   end

   assign Read_data_1 = operand[0];
   assign Read_data_2 = operand[1];
endmodule
